// File: rtl/seq_alu_pkg.sv
// Shared opcode, state and decode definitions for the sequential execute-stage ALU.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_ADDMS = 4'b0011;
  localparam logic [3:0] OP_ANDN  = 4'b0100;
  localparam logic [3:0] OP_ORN   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_XOR   = 4'b1000;
  localparam logic [3:0] OP_NOR   = 4'b1001;
  localparam logic [3:0] OP_SLL   = 4'b1010;
  localparam logic [3:0] OP_SRL   = 4'b1011;
  localparam logic [3:0] OP_SRA   = 4'b1100;
  localparam logic [3:0] OP_SLTU  = 4'b1101;
  localparam logic [3:0] OP_MULTU = 4'b1110;
  localparam logic [3:0] OP_DIVU  = 4'b1111;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // The low half of the opcode space is the old 3-bit ALU, bit for bit.
  function automatic logic is_legacy(input logic [3:0] op);
    return !op[3];
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return op[3:1] == 3'b111;
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one bit per clock.
module seq_alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             div_zero_o
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] b_q;
  logic             is_div_q;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_diff;

  // Multiply: {acc,q} holds partial product and remaining multiplier bits.
  assign mul_sum   = {1'b0, acc_q} + (q_q[0] ? {1'b0, b_q} : '0);
  // Divide: acc is the partial remainder, q shifts dividend out and quotient in.
  // When div_ge holds the difference is below b_q, so WIDTH bits suffice.
  assign div_shift = {acc_q, q_q[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, b_q};
  assign div_diff  = div_shift[WIDTH-1:0] - b_q;

  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    cnt_d = cnt_q;
    acc_d = acc_q;
    q_d   = q_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      if (is_div_q) begin
        acc_d = div_ge ? div_diff : div_shift[WIDTH-1:0];
        q_d   = {q_q[WIDTH-2:0], div_ge};
      end else begin
        acc_d = mul_sum[WIDTH:1];
        q_d   = {mul_sum[0], q_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking updates so every register sees pre-edge values.
    if (rst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      b_q      <= '0;
      is_div_q <= 1'b0;
    end else if (start_i) begin
      cnt_q    <= CW'(WIDTH);
      acc_q    <= '0;
      q_q      <= a_i;
      b_q      <= b_i;
      is_div_q <= is_div_i;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      q_q   <= q_d;
    end
  end

  // Results are the values the final iteration is about to write.
  // A zero divisor needs no special case: quotient becomes all-ones, remainder a.
  assign done_o     = (cnt_q == CW'(1));
  assign lo_o       = q_d;
  assign hi_o       = acc_d;
  assign div_zero_o = is_div_q && (b_q == '0);

endmodule

// File: rtl/seq_alu.sv
// Registered execute-stage ALU: single-cycle logic/shift ops plus iterative MULTU/DIVU.
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero
);

  localparam int SHW = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             accept, multi, start;
  logic [WIDTH-1:0] bout, sum, res_d;
  logic [SHW-1:0]   shamt;
  logic             ovf_d;

  logic             out_valid_q, zero_q, ovf_q, dz_q;
  logic [WIDTH-1:0] y_q, hi_q;

  logic             md_done, md_dz;
  logic [WIDTH-1:0] md_lo, md_hi;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid && in_ready;
  assign multi    = is_muldiv(op);
  assign start    = accept && multi;

  always_comb begin
    bout  = op[2] ? ~b : b;
    sum   = a + bout + {{(WIDTH-1){1'b0}}, op[2]};
    shamt = b[SHW-1:0];
    res_d = '0;
    if (is_legacy(op)) begin
      case (op[1:0])
        2'b00:   res_d = a & bout;
        2'b01:   res_d = a | bout;
        2'b10:   res_d = sum;
        default: res_d = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
      endcase
    end else begin
      case (op)
        OP_XOR:  res_d = a ^ b;
        OP_NOR:  res_d = ~(a | b);
        OP_SLL:  res_d = a << shamt;
        OP_SRL:  res_d = a >> shamt;
        OP_SRA:  res_d = $unsigned($signed(a) >>> shamt);
        OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (a < b)};
        default: res_d = '0;
      endcase
    end
    // Legacy SLT keeps the raw sign of the difference, so only ADD/SUB flag overflow.
    ovf_d = ((op == OP_ADD) || (op == OP_SUB)) &&
            (a[WIDTH-1] == bout[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (md_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .rst        (rst),
    .start_i    (start),
    .is_div_i   (op[0]),
    .a_i        (a),
    .b_i        (b),
    .done_o     (md_done),
    .lo_o       (md_lo),
    .hi_o       (md_hi),
    .div_zero_o (md_dz)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      y_q         <= '0;
      hi_q        <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      dz_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= 1'b0;
      if (accept && !multi) begin
        out_valid_q <= 1'b1;
        y_q         <= res_d;
        hi_q        <= '0;
        zero_q      <= (res_d == '0);
        ovf_q       <= ovf_d;
        dz_q        <= 1'b0;
      end else if (state_q == RUN && md_done) begin
        out_valid_q <= 1'b1;
        y_q         <= md_lo;
        hi_q        <= md_hi;
        zero_q      <= (md_lo == '0);
        ovf_q       <= 1'b0;
        dz_q        <= md_dz;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign y         = y_q;
  assign hi        = hi_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign div_zero  = dz_q;

endmodule

// File: tb/tb_seq_alu.sv
// Scoreboard bench for seq_alu: arithmetic reference model, queued expectations, decoupled monitor.
module tb_seq_alu;
  import seq_alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, zero, overflow, div_zero;
  logic [W-1:0] y, hi;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .y         (y),
    .hi        (hi),
    .zero      (zero),
    .overflow  (overflow),
    .div_zero  (div_zero)
  );

  // lat counts clock edges after the accept edge before out_valid is visible:
  // 0 for single-cycle ops (visible right after accept), W for MULTU/DIVU.
  typedef struct {
    logic [W-1:0] y;
    logic [W-1:0] hi;
    logic         zero;
    logic         ovf;
    logic         dz;
    int           acc_cyc;
    int           lat;
  } exp_t;

  exp_t sb_q[$];
  int   cyc      = 0;
  int   n_vec    = 0;
  int   n_err    = 0;
  int   busy_acc = -1000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    exp_t         e;
    logic [W-1:0] r, t;
    logic [63:0]  p;
    longint       sx, sz;
    sx    = longint'($signed(x));
    sz    = longint'($signed(z));
    r     = '0;
    e.hi  = '0;
    e.ovf = 1'b0;
    e.dz  = 1'b0;
    e.lat = 0;
    e.acc_cyc = 0;
    case (o)
      OP_AND:   r = x & z;
      OP_OR:    r = x | z;
      OP_ADD:   begin r = x + z; e.ovf = (sx + sz) != longint'($signed(r)); end
      OP_ADDMS: begin t = x + z; r = {31'b0, t[31]}; end
      OP_ANDN:  r = x & ~z;
      OP_ORN:   r = x | ~z;
      OP_SUB:   begin r = x - z; e.ovf = (sx - sz) != longint'($signed(r)); end
      OP_SLT:   begin t = x - z; r = {31'b0, t[31]}; end
      OP_XOR:   r = x ^ z;
      OP_NOR:   r = ~(x | z);
      OP_SLL:   r = x << z[4:0];
      OP_SRL:   r = x >> z[4:0];
      OP_SRA:   r = $unsigned($signed(x) >>> z[4:0]);
      OP_SLTU:  r = (x < z) ? 32'd1 : 32'd0;
      OP_MULTU: begin
        p = 64'(x) * 64'(z);
        r = p[31:0];
        e.hi = p[63:32];
        e.lat = W;
      end
      default: begin
        if (z == '0) begin
          r = '1; e.hi = x; e.dz = 1'b1;
        end else begin
          r = x / z; e.hi = x % z;
        end
        e.lat = W;
      end
    endcase
    e.y    = r;
    e.zero = (r == '0);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return '1;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return W'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  // Called at a falling edge; the next rising edge is the accept edge.
  task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] z);
    exp_t e;
    int   guard = 0;
    while (!in_ready) begin
      in_valid = 1'b0;
      @(negedge clk);
      guard++;
      if (guard > 4 * W) begin
        check("issue_wait_in_ready", in_ready, 1);
        return;
      end
    end
    e = model(o, x, z);
    e.acc_cyc = cyc + 1;
    op = o; a = x; b = z; in_valid = 1'b1;
    sb_q.push_back(e);
    if (is_muldiv(o)) busy_acc = cyc + 1;
    @(negedge clk);
    in_valid = 1'b0;
    a = $urandom;
    b = $urandom;
    op = 4'($urandom);
  endtask

  // Request presented while the block is busy; it must be dropped.
  task automatic poke();
    in_valid = 1'b1;
    op = 4'($urandom);
    a = $urandom;
    b = $urandom;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    in_valid = 1'b0;
    sb_q.delete();
    busy_acc = -1000;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      check("in_ready", in_ready, (cyc >= busy_acc && cyc < busy_acc + W) ? 0 : 1);
      if (out_valid) begin
        if (sb_q.size() == 0) begin
          check("spurious_out_valid", out_valid, 0);
        end else begin
          e = sb_q.pop_front();
          check("y", y, e.y);
          check("hi", hi, e.hi);
          check("zero", zero, e.zero);
          check("overflow", overflow, e.ovf);
          check("div_zero", div_zero, e.dz);
          check("latency", cyc - e.acc_cyc, e.lat);
        end
      end else if (sb_q.size() > 0 && cyc > sb_q[0].acc_cyc + sb_q[0].lat) begin
        check("out_valid_timeout", out_valid, 1);
        void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int guard;
    @(negedge clk);
    do_reset(2);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_hi", hi, 0);
    check("rst_zero", zero, 1);
    check("rst_overflow", overflow, 0);
    check("rst_div_zero", div_zero, 0);

    issue(OP_ADD, 32'd7, 32'd5);
    issue(OP_SUB, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    issue(OP_SUB, 32'h8000_0000, 32'd1);
    issue(OP_SLT, 32'd3, 32'd5);
    issue(OP_ANDN, 32'hFF, 32'h0F);
    issue(OP_XOR, 32'hA5A5_0F0F, 32'h0FF0_FFFF);
    issue(OP_SRA, 32'h8000_0000, 32'd4);
    issue(OP_SLTU, 32'd1, 32'hFFFF_FFFF);
    issue(OP_SLL, 32'h1, 32'hFFFF_FFFF);

    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (3) begin poke(); @(negedge clk); end
    issue(OP_DIVU, 32'd100, 32'd7);
    issue(OP_DIVU, 32'd9, 32'd0);
    issue(OP_ADD, 32'd1, 32'hFFFF_FFFF);

    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    do_reset(1);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_y", y, 0);
    repeat (W + 4) @(negedge clk);
    issue(OP_ADD, 32'd20, 32'd22);

    for (int i = 0; i < 250; i++) begin
      logic [3:0] o;
      o = 4'($urandom_range(0, 15));
      issue(o, rand_operand(), rand_operand());
      if (is_muldiv(o) && $urandom_range(0, 1) == 1) poke();
      if ($urandom_range(0, 7) == 0) @(negedge clk);
    end

    guard = 0;
    while (sb_q.size() > 0 && guard < 4 * W) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU, for the multi-cycle CPU execute stage.
- Keeps the legacy 3-bit operation semantics as a subset of a 4-bit opcode.
- Adds XOR, NOR, shifts and unsigned set-less-than.
- Adds iterative unsigned multiply and divide, using a valid/ready handshake and a busy FSM so the controller can stall.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridable).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- op  in  4  opcode (see Behaviour)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B; also the shift amount via b[SHW-1:0]
- out_valid  out  1  one-cycle pulse: y/hi/flags updated this cycle
- y  out  WIDTH  result; low product; quotient
- hi  out  WIDTH  high product; remainder; 0 for single-cycle ops
- zero  out  1  y == 0
- overflow  out  1  signed overflow, ADD/SUB only, else 0
- div_zero  out  1  DIVU with b == 0, else 0

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, y=0, hi=0, zero=1, overflow=0, div_zero=0.
- Reset mid-operation aborts it: no out_valid, operands discarded.
- Accept: at a rising edge with in_valid && in_ready. a, b and op are captured at that edge and may change afterwards.
- Opcodes 0000–0111 reproduce the legacy 3-bit ALU:
  - bout = op[2] ? ~b : b
  - s = a + bout + op[2]
  - op[1:0]: 00 → a & bout; 01 → a | bout; 10 → s; 11 → {0…, s[WIDTH-1]}
  - 0010 is ADD, 0110 is SUB, 0111 is signed SLT (sign of difference, legacy-compatible; no overflow correction).
- Single-cycle extended opcodes:
  - 1000 XOR
  - 1001 NOR
  - 1010 SLL a by b[SHW-1:0]
  - 1011 SRL
  - 1100 SRA
  - 1101 SLTU (true unsigned compare)
- Single-cycle timing: results registered at the accept edge. out_valid is high the following cycle (latency 1), hi=0, and in_ready stays 1, so back-to-back issue gives one result per cycle.
- Multi-cycle opcodes 1110 MULTU and 1111 DIVU:
  - Accept edge loads the working registers, sets cnt=WIDTH, state=RUN, in_ready=0.
  - Each subsequent edge does one iteration and decrements cnt.
  - The edge where cnt goes 1→0 writes y/hi, pulses out_valid and returns to IDLE.
  - Latency is WIDTH cycles from the accept edge (32 for WIDTH=32). in_ready rises in the out_valid cycle.
- MULTU: shift-add; {hi,y} = a*b, unsigned, full 2·WIDTH product.
- DIVU: restoring, one quotient bit per cycle; y = a/b, hi = a%b.
- Divide by zero: still takes WIDTH cycles; y = all-ones, hi = a, div_zero=1.
- Flags:
  - zero = (y == 0) for the registered y.
  - overflow = (a[msb]==bout[msb]) && (s[msb]!=a[msb]) for op 0010/0110, else 0.
  - div_zero cleared by any other op.
- Hold: y/hi/flags hold between out_valid pulses. in_valid while busy is ignored and not queued.
- Shift amounts ≥ WIDTH are impossible: only b[SHW-1:0] is used.

Decomposition:
- Package seq_alu_pkg holds:
  - opcode localparams OP_AND…OP_DIVU
  - state encoding IDLE/RUN
  - the legacy-subset predicate: op[3]==0.
- One sub-module, seq_alu_muldiv: iterative MULTU/DIVU datapath with start, is_div, done and the cnt counter.
- Single-cycle logic and the FSM stay in seq_alu.

Test Plan:
- Reset: assert rst 2 cycles → in_ready=1, y=0, zero=1, out_valid=0. Issue ADD 7+5 → next cycle y=12, out_valid=1, zero=0.
- Legacy/overflow: SUB 0x7FFFFFFF − 0xFFFFFFFF → y=0x80000000, overflow=1. SLT 3,5 → y=1. op 0100 with a=0xFF, b=0x0F → y=0xF0.
- Back-to-back: XOR, SRA 0x80000000>>4, SLTU 1 vs 0xFFFFFFFF on consecutive cycles → y=…, 0xF8000000, 1 on consecutive cycles, in_ready never low.
- MULTU 0xFFFFFFFF*0xFFFFFFFF → out_valid exactly 32 cycles after accept, hi=0xFFFFFFFE, y=0x00000001. in_valid pulses during RUN are ignored.
- DIVU 100/7 → y=14, hi=2. DIVU 9/0 → y=0xFFFFFFFF, hi=9, div_zero=1, same 32-cycle latency.
- Reset mid-DIVU at cycle 10 → no out_valid, in_ready=1 next cycle, y=0. A new ADD then completes normally.
